tif: RTL and testbench

Byte-wide UART transmit interface: the outgoing counterpart of the RIF receiver. It accepts one byte per valid/ready handshake and serialises it onto `txd` as 8N1: one start bit, 8 data bits LSB first, one stop bit. Each bit lasts `BIT_CYCLES` clocks. Its default bit timing matches RIF, so a TIF→RIF loopback works in the SDU/regfile lab bench.

---
 rtl/tif_pkg.sv | 17 +
 rtl/tif_if.sv | 11 +
 rtl/tif_bit_timer.sv | 27 ++
 rtl/tif.sv | 97 +++++++++
 tb/tb_tif.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/tif_pkg.sv
// Shared types and constants for the TIF UART transmitter.
// Frame lengths cover both the 8N1 build and the TIF_PARITY_EN build.
package tif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tif_state_t;

  localparam int TIF_DATA_BITS         = 8;
  localparam int TIF_FRAME_BITS_8N1    = TIF_DATA_BITS + 2;
  localparam int TIF_FRAME_BITS_PARITY = TIF_DATA_BITS + 3;

endpackage

// File: rtl/tif_if.sv
// Byte handshake between a producer (master) and the TIF transmitter (slave).
interface tif_if;
  import tif_pkg::*;

  logic                     tx_vld;
  logic                     tx_rdy;
  logic [TIF_DATA_BITS-1:0] din;

  modport master (output tx_vld, output din, input tx_rdy);
  modport slave  (input tx_vld, input din, output tx_rdy);
endinterface

// File: rtl/tif_bit_timer.sv
// Free-running bit-period counter: counts 0..BIT_CYCLES-1, wraps on terminal
// count, and is held at zero while clr is high.
module bit_timer #(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);
  localparam int W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(BIT_CYCLES - 1);

  logic [W-1:0] cnt_reg;

  assign tc = (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || tc) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end
endmodule

// File: rtl/tif.sv
// UART transmitter: one byte per valid/ready handshake, sent 8N1 LSB first.
// Define TIF_PARITY_EN to insert an even-parity bit before the stop bit.
module tif
  import tif_pkg::*;
#(
  parameter int BIT_CYCLES = 16
) (
  input  logic  clk,
  input  logic  rst,
  tif_if.slave  bus,
  output logic  txd
);
  tif_state_t               state_reg;
  logic [TIF_DATA_BITS-1:0] shift_reg;
  logic [2:0]               idx_reg;
  logic                     txd_reg;
  logic                     tc;
  logic                     take;
`ifdef TIF_PARITY_EN
  logic                     par_reg;
`endif

  // Ready in IDLE and in the last clock of STOP so frames can abut.
  assign bus.tx_rdy = (state_reg == IDLE) || ((state_reg == STOP) && tc);
  assign take       = bus.tx_vld && bus.tx_rdy;
  assign txd        = txd_reg;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_reg == IDLE),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      txd_reg   <= 1'b1;
`ifdef TIF_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      // Handshake is only possible in IDLE or the final STOP clock.
      if (take) begin
        state_reg <= START;
        shift_reg <= bus.din;
        idx_reg   <= '0;
        txd_reg   <= 1'b0;
`ifdef TIF_PARITY_EN
        par_reg   <= ^bus.din;
`endif
      end else if (tc) begin
        case (state_reg)
          START: begin
            state_reg <= DATA;
            txd_reg   <= shift_reg[0];
          end
          DATA: begin
            shift_reg <= shift_reg >> 1;
            if (idx_reg == 3'(TIF_DATA_BITS - 1)) begin
              idx_reg <= '0;
`ifdef TIF_PARITY_EN
              state_reg <= PARITY;
              txd_reg   <= par_reg;
`else
              state_reg <= STOP;
              txd_reg   <= 1'b1;
`endif
            end else begin
              idx_reg <= idx_reg + 3'd1;
              txd_reg <= shift_reg[1];
            end
          end
`ifdef TIF_PARITY_EN
          PARITY: begin
            state_reg <= STOP;
            txd_reg   <= 1'b1;
          end
`endif
          STOP: begin
            state_reg <= IDLE;
            txd_reg   <= 1'b1;
          end
          IDLE: begin
            txd_reg <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            txd_reg   <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tif.sv
// Bench for tif: cycle-by-cycle comparison of txd/tx_rdy against a frame-level
// model (bit list per byte, frame start/end cycle), plus directed literal checks.
module tb_tif;

  localparam int BC = 16;
`ifdef TIF_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic clk;
  logic rst;
  logic txd;

  tif_if bus ();

  tif #(.BIT_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   frame_start = 0;
  int   frame_end   = 0;
  logic frame_bits [0:10];
  int   hs_model = 0;
  int   hs_obs   = 0;
  int   last_hs_cyc = 0;
  logic last_hs;
  logic obs_txd;
  logic obs_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
    end
  endtask

  // One clock interval: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input logic vld, input logic [7:0] d);
    logic exp_txd;
    logic exp_rdy;
    @(negedge clk);
    bus.tx_vld = vld;
    bus.din    = d;
    #1;
    obs_txd = txd;
    obs_rdy = bus.tx_rdy;
    exp_txd = (cyc < frame_end) ? frame_bits[(cyc - frame_start) / BC] : 1'b1;
    exp_rdy = (cyc >= frame_end - 1);
    check("txd", obs_txd, exp_txd);
    check("tx_rdy", obs_rdy, exp_rdy);
    if (vld && obs_rdy) hs_obs++;
    last_hs = vld && exp_rdy;
    if (last_hs) begin
      frame_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) frame_bits[1 + i] = d[i];
      frame_bits[9]  = ($countones(d) % 2 == 1);
      frame_bits[FL - 1] = 1'b1;
      frame_start = cyc + 1;
      frame_end   = cyc + 1 + FL * BC;
      hs_model++;
      last_hs_cyc = cyc;
      $display("tb: cycle %0d handshake byte %02h", cyc, d);
    end
    cyc++;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    do begin
      step(1'b1, d);
      n++;
    end while (!last_hs && n < 4 * FL * BC);
    if (!last_hs) check("hs_timeout", 32'd0, 32'd1);
  endtask

  // Steps idle through the frame just accepted, checking bit centres and length.
  task automatic sample_frame(input string name, input logic [10:0] exp_vec);
    int first_rdy;
    first_rdy = -1;
    for (int k = 0; k < FL * BC + 2; k++) begin
      step(1'b0, 8'h00);
      if ((k % BC) == BC / 2 && (k / BC) < FL)
        check($sformatf("%s_bit%0d", name, k / BC), obs_txd, exp_vec[k / BC]);
      if (obs_rdy && first_rdy < 0) first_rdy = k;
    end
    check({name, "_len"}, first_rdy + 1, FL * BC);
    $display("tb: frame %s checked", name);
  endtask

  task automatic hold_reset(input int n, input logic vld);
    rst = 1'b1;
    bus.tx_vld = vld;
    bus.din    = 8'hC3;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check("rst_txd", txd, 1'b1);
      check("rst_rdy", bus.tx_rdy, 1'b1);
      cyc++;
    end
    frame_start = cyc;
    frame_end   = cyc;
    rst = 1'b0;
    bus.tx_vld = 1'b0;
    $display("tb: reset released at cycle %0d", cyc);
  endtask

  task automatic idle_until_free();
    while (cyc < frame_end) step(1'b0, 8'h00);
  endtask

  initial begin
    int h1, h2, hs_before;
    logic [7:0] d;
    logic [10:0] v65, vff, v3c;
`ifdef TIF_PARITY_EN
    v65 = 11'b10011001010;
    vff = 11'b10111111110;
    v3c = 11'b10001111000;
`else
    v65 = 11'b01011001010;
    vff = 11'b01111111110;
    v3c = 11'b01001111000;
`endif
    rst = 1'b1;
    bus.tx_vld = 1'b0;
    bus.din    = 8'h00;

    hold_reset(3, 1'b0);
    repeat (200) step(1'b0, 8'($urandom));

    // Single byte.
    send(8'h65);
    sample_frame("single65", v65);

    // Back-to-back with tx_vld held.
    hs_before = hs_obs;
    send(8'h65);
    h1 = last_hs_cyc;
    send(8'hFF);
    h2 = last_hs_cyc;
    check("b2b_gap", h2 - h1, FL * BC);
    sample_frame("b2bFF", vff);
    check("b2b_hs", hs_obs - hs_before, 2);

    // Ignored input during a frame.
    hs_before = hs_obs;
    send(8'h5A);
    while (cyc < frame_end - 1) step(1'($urandom_range(0, 1)), 8'($urandom));
    idle_until_free();
    repeat (4) step(1'b0, 8'h00);
    check("ignored_hs", hs_obs - hs_before, 1);

    // Reset during data bit 3; simultaneous tx_vld must not be captured.
    send(8'hA5);
    repeat (4 * BC + 3) step(1'b0, 8'h00);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.tx_vld = 1'b1;
    #1;
    check("rst_async_txd", txd, 1'b1);
    cyc++;
    hold_reset(2, 1'b1);
    repeat (5) step(1'b0, 8'h00);
    send(8'h3C);
    sample_frame("after_rst3C", v3c);

`ifdef TIF_PARITY_EN
    send(8'h07);
    sample_frame("par07", 11'b11000001110);
`endif

    // Randomized traffic, including zero-gap back-to-back frames.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 8'($urandom));
      d = 8'($urandom);
      send(d);
      while (cyc < frame_end - 1) step(1'($urandom_range(0, 1)), 8'($urandom));
    end
    idle_until_free();
    repeat (4) step(1'b0, 8'h00);
    check("hs_total", hs_obs, hs_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
